// File: rtl/alu_pkg.sv
// Shared constants for the 1-bit ALU slice.
// Opcode encodings used by every slice in the chain.
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder used inside each ALU slice.
// Pure combinational sum and majority carry.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/alu_1bit.sv
// One-bit ALU slice: AND/OR/ADD/XOR with carry chain.
// Combinational outputs plus a registered, reset-clean copy.
module alu_1bit
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       BInvert,
    input  logic [1:0] Operation,
    output logic       Result,
    output logic       cout,
    output logic       Result_r,
    output logic       cout_r
);

    logic bb;
    logic sum;

    // inverted operand feeds every op, so SUB and NAND-style tricks share it
    assign bb = b ^ BInvert;

    full_adder_1bit u_fa (
        .a    (a),
        .b    (bb),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    // 4:1 result select; carry is produced regardless of opcode
    always_comb begin
        Result = 1'b0;
        unique case (1'b1)
            (Operation == OP_AND): Result = a & bb;
            (Operation == OP_OR):  Result = a | bb;
            (Operation == OP_ADD): Result = sum;
            (Operation == OP_XOR): Result = a ^ bb;
            default:               Result = 1'b0;
        endcase
    end

    // registered copy of the slice outputs, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Result_r <= 1'b0;
            cout_r   <= 1'b0;
        end else begin
            Result_r <= Result;
            cout_r   <= cout;
        end
    end

endmodule

// File: tb/tb_alu_1bit.sv
// Self-checking bench for alu_1bit.
// Directed table cases plus random steps against an arithmetic model.
module tb_alu_1bit;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       cin;
    logic       BInvert;
    logic [1:0] Operation;
    logic       Result;
    logic       cout;
    logic       Result_r;
    logic       cout_r;

    int checks;
    int errors;

    logic exp_r;
    logic exp_c;

    alu_1bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .BInvert   (BInvert),
        .Operation (Operation),
        .Result    (Result),
        .cout      (cout),
        .Result_r  (Result_r),
        .cout_r    (cout_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: treat the slice as integer addition and bitwise logic
    function automatic logic [1:0] model(
        input logic xa, input logic xb, input logic xc,
        input logic inv, input logic [1:0] op
    );
        int ia, ib, s;
        logic r;
        ia = int'(xa);
        ib = (inv) ? 1 - int'(xb) : int'(xb);
        s  = ia + ib + int'(xc);
        case (op)
            2'd0:    r = (ia * ib) != 0;
            2'd1:    r = (ia + ib) != 0;
            2'd2:    r = (s % 2) != 0;
            default: r = ((ia + ib) % 2) != 0;
        endcase
        return {s >= 2, r};
    endfunction

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic drive(
        input logic xa, input logic xb, input logic xc,
        input logic inv, input logic [1:0] op
    );
        logic [1:0] m;
        a = xa;
        b = xb;
        cin = xc;
        BInvert = inv;
        Operation = op;
        m = model(xa, xb, xc, inv, op);
        exp_r = m[0];
        exp_c = m[1];
        #1;
        check("comb_result", Result, exp_r);
        check("comb_cout", cout, exp_c);
    endtask

    // drive at negedge, then confirm the register picked it up at posedge
    task automatic step(
        input logic xa, input logic xb, input logic xc,
        input logic inv, input logic [1:0] op
    );
        @(negedge clk);
        drive(xa, xb, xc, inv, op);
        @(posedge clk);
        #1;
        check("reg_result", Result_r, exp_r);
        check("reg_cout", cout_r, exp_c);
    endtask

    logic [1:0] tbl_and [4];
    logic [1:0] tbl_add [4];
    logic [1:0] tbl_sub [4];
    logic [3:0] vand;
    logic [3:0] vor;
    logic [3:0] vxor;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b1;
        a = 1'b1;
        b = 1'b1;
        cin = 1'b0;
        BInvert = 1'b0;
        Operation = 2'b10;

        // async reset before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_result_r", Result_r, 1'b0);
        check("rst_cout_r", cout_r, 1'b0);
        check("rst_comb_result", Result, 1'b0);
        check("rst_comb_cout", cout, 1'b1);

        @(posedge clk);
        #1;
        check("rst_hold_result_r", Result_r, 1'b0);
        check("rst_hold_cout_r", cout_r, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
        @(posedge clk);
        #1;
        check("release_result_r", Result_r, 1'b1);
        check("release_cout_r", cout_r, 1'b0);

        // spec tables, indexed by {a,b}
        vand = 4'b1000;
        vor  = 4'b1110;
        vxor = 4'b0110;
        tbl_add[0] = 2'b00; tbl_add[1] = 2'b10;
        tbl_add[2] = 2'b10; tbl_add[3] = 2'b01;
        tbl_sub[0] = 2'b01; tbl_sub[1] = 2'b10;
        tbl_sub[2] = 2'b11; tbl_sub[3] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            drive(i[1], i[0], 1'b0, 1'b0, 2'b00);
            check("tbl_and", Result, vand[i]);
            drive(i[1], i[0], 1'b0, 1'b0, 2'b01);
            check("tbl_or", Result, vor[i]);
            drive(i[1], i[0], 1'b0, 1'b0, 2'b11);
            check("tbl_xor", Result, vxor[i]);
            drive(i[1], i[0], 1'b0, 1'b0, 2'b10);
            check("tbl_add_r", Result, tbl_add[i][1]);
            check("tbl_add_c", cout, tbl_add[i][0]);
            drive(i[1], i[0], 1'b1, 1'b1, 2'b10);
            check("tbl_sub_r", Result, tbl_sub[i][1]);
            check("tbl_sub_c", cout, tbl_sub[i][0]);
        end

        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10);
        check("add_111_r", Result, 1'b1);
        check("add_111_c", cout, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
        check("binv_and", Result, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
        check("binv_or", Result, 1'b1);

        // random steps, one-cycle latency on the registered view
        for (int n = 0; n < 200; n++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 2'($urandom));
        end

        // reset mid-run: register clears, comb keeps tracking
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10);
        @(posedge clk);
        #1;
        check("pre_rst_r", Result_r, 1'b1);
        check("pre_rst_c", cout_r, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_r", Result_r, 1'b0);
        check("mid_rst_c", cout_r, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
        @(posedge clk);
        #1;
        check("mid_rst_hold_r", Result_r, 1'b0);
        check("mid_rst_comb", Result, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'b10);

        for (int n = 0; n < 50; n++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 2'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
